// File: rtl/pdm_sample_packer_if.sv
// Capture-side bundle of the PDM sample packer: enable and mic data in,
// generated mic clock and packed RAM word out.
interface pdm_sample_packer_if #(
  parameter int SAMPLE_W = 8
);
  logic                    count_en;
  logic                    micData;
  logic                    mic_clk;
  logic [4*SAMPLE_W-1:0]   ram_data;
  logic                    ram_wr;

  // The packer drives the mic clock and the RAM word.
  modport master (
    input  count_en,
    input  micData,
    output mic_clk,
    output ram_data,
    output ram_wr
  );

  // The control FSM / microphone side.
  modport slave (
    output count_en,
    output micData,
    input  mic_clk,
    input  ram_data,
    input  ram_wr
  );
endinterface

// File: rtl/pdm_sample_packer.sv
// PDM front end: divides clk down to the microphone clock, counts ones in the
// bitstream over a CLOCKS-bit window to form one sample, and packs four
// samples (lane 0 in the LSBs) into a RAM word with a one-cycle write strobe.
module pdm_sample_packer #(
  parameter int MIC_DIV  = 42,
  parameter int CLOCKS   = 240,
  parameter int COUNT_W  = 8,
  parameter int SAMPLE_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  pdm_sample_packer_if.master bus
);

  localparam int                 DIV_W    = $clog2(MIC_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(MIC_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(MIC_DIV / 2);
  localparam logic [COUNT_W-1:0] BIT_LAST = COUNT_W'(CLOCKS - 1);

  // A single-cycle drop of count_en parks in HOLD and keeps the partial
  // sample; a second consecutive low cycle falls back to IDLE and clears it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [DIV_W-1:0]             div;
  logic [DIV_W-1:0]             div_next;
  logic                         strobe;
  logic                         counted;
  logic                         window_end;
  logic                         word_end;
  logic [COUNT_W-1:0]           bit_cnt;
  logic [SAMPLE_W-1:0]          ones_cnt;
  logic [SAMPLE_W:0]            ones_inc;
  logic [SAMPLE_W-1:0]          ones_sat;
  logic [1:0]                   lane;
  logic [2:0][SAMPLE_W-1:0]     lanes;

  assign div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

  // The bit strobe is the last clk of the mic_clk low phase, so micData has
  // had the whole low half-period to settle.
  assign strobe     = (div == DIV_LAST);
  assign counted    = strobe && (state == RUN) && bus.count_en;
  assign window_end = counted && (bit_cnt == BIT_LAST);
  assign word_end   = window_end && (lane == 2'd3);

  // Ones count including the current bit, saturated to the sample width.
  assign ones_inc = {1'b0, ones_cnt} + {{SAMPLE_W{1'b0}}, bus.micData};
  assign ones_sat = ones_inc[SAMPLE_W] ? '1 : ones_inc[SAMPLE_W-1:0];

  // Free-running divider and registered 50% duty mic clock.
  // NOTE: every clocked register uses <= so all flops sample the same
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div         <= '0;
      bus.mic_clk <= 1'b0;
    end else begin
      div         <= div_next;
      bus.mic_clk <= (div_next < DIV_HALF);
    end
  end

  // Capture state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic driven purely by count_en.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.count_en) state_next = RUN;
      RUN:     if (!bus.count_en) state_next = HOLD;
      HOLD:    state_next = bus.count_en ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window bit count, ones count and lane bookkeeping; zeroed whenever the
  // machine is (or is about to be) idle so no stale partial survives.
  // NOTE: the lane buffer is reset only for deterministic startup; it is not
  // cleared on IDLE because a word always rewrites lanes 0..2 before use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
      lane     <= '0;
      lanes    <= '0;
    end else if (state_next == IDLE) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
      lane     <= '0;
    end else if (counted) begin
      if (window_end) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
        lane     <= lane + 2'd1;
        for (int i = 0; i < 3; i++) begin
          if (lane == 2'(i)) lanes[i] <= ones_sat;
        end
      end else begin
        bit_cnt  <= bit_cnt + COUNT_W'(1);
        ones_cnt <= ones_sat;
      end
    end
  end

  // Word output: lane 3 goes straight from the count into the MSBs, and the
  // strobe lasts exactly the one cycle after the completing bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ram_wr   <= 1'b0;
      bus.ram_data <= '0;
    end else begin
      bus.ram_wr <= word_end;
      if (word_end) begin
        bus.ram_data <= {ones_sat, lanes};
      end
    end
  end

endmodule

// File: tb/tb_pdm_sample_packer.sv
// Self-checking bench for pdm_sample_packer. Two instances (8-bit and 3-bit
// samples) share one stimulus stream; a queue-based reference model collects
// counted bits and forms each word by plain summation with saturation.
module tb_pdm_sample_packer;

  localparam int MIC_DIV   = 4;
  localparam int CLOCKS    = 8;
  localparam int COUNT_W   = 4;
  localparam int SW8       = 8;
  localparam int SW3       = 3;
  localparam int WORD_BITS = 4 * CLOCKS;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic count_en = 1'b0;
  logic mic_data = 1'b0;

  always #5 clk = ~clk;

  pdm_sample_packer_if #(.SAMPLE_W(SW8)) bus8 ();
  pdm_sample_packer_if #(.SAMPLE_W(SW3)) bus3 ();

  assign bus8.count_en = count_en;
  assign bus8.micData  = mic_data;
  assign bus3.count_en = count_en;
  assign bus3.micData  = mic_data;

  pdm_sample_packer #(
    .MIC_DIV(MIC_DIV), .CLOCKS(CLOCKS), .COUNT_W(COUNT_W), .SAMPLE_W(SW8)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.master)
  );

  pdm_sample_packer #(
    .MIC_DIV(MIC_DIV), .CLOCKS(CLOCKS), .COUNT_W(COUNT_W), .SAMPLE_W(SW3)
  ) dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          cyc;
  bit          prev_en;
  bit          bits[$];
  logic        exp_wr;
  logic        exp_mic;
  logic [31:0] exp_d8;
  logic [11:0] exp_d3;

  // Observed write strobes (cycle index and data) for targeted checks.
  int          wr_cycles[$];
  logic [31:0] wr_data8[$];
  logic [31:0] wr_data3[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int wr_at(input int i);
    return (i < wr_cycles.size()) ? wr_cycles[i] : -1;
  endfunction

  function automatic logic [31:0] wd8_at(input int i);
    return (i < wr_data8.size()) ? wr_data8[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wd3_at(input int i);
    return (i < wr_data3.size()) ? wr_data3[i] : 32'hDEAD_BEEF;
  endfunction

  // Each lane is the number of ones in its window, clamped to the sample range.
  task automatic pack_word();
    int ones;
    for (int l = 0; l < 4; l++) begin
      ones = 0;
      for (int b = 0; b < CLOCKS; b++) ones += int'(bits[l*CLOCKS + b]);
      exp_d8[l*SW8 +: SW8] = (ones > 255) ? 8'd255 : 8'(ones);
      exp_d3[l*SW3 +: SW3] = (ones > 7) ? 3'd7 : 3'(ones);
    end
  endtask

  // A strobe counts when count_en was high on this and the previous cycle;
  // two consecutive low cycles throw away the partial word.
  task automatic model_step(input bit en, input bit d);
    if (!rst) begin
      cyc     = 0;
      prev_en = 1'b0;
      bits.delete();
      exp_wr  = 1'b0;
      exp_mic = 1'b0;
      exp_d8  = '0;
      exp_d3  = '0;
    end else begin
      exp_wr = 1'b0;
      if ((cyc % MIC_DIV == MIC_DIV - 1) && prev_en && en) begin
        bits.push_back(d);
        if (bits.size() == WORD_BITS) begin
          pack_word();
          exp_wr = 1'b1;
          bits.delete();
        end
      end else if (!en && !prev_en) begin
        bits.delete();
      end
      exp_mic = (((cyc + 1) % MIC_DIV) < MIC_DIV / 2);
      prev_en = en;
      cyc++;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at negedge.
  task automatic tick(input bit en, input bit d);
    count_en = en;
    mic_data = d;
    @(posedge clk);
    model_step(en, d);
    @(negedge clk);
    check("ram_wr",      32'(bus8.ram_wr),   32'(exp_wr));
    check("ram_data",    bus8.ram_data,      exp_d8);
    check("mic_clk",     32'(bus8.mic_clk),  32'(exp_mic));
    check("ram_wr_w3",   32'(bus3.ram_wr),   32'(exp_wr));
    check("ram_data_w3", 32'(bus3.ram_data), 32'(exp_d3));
    if (bus8.ram_wr) begin
      wr_cycles.push_back(cyc);
      wr_data8.push_back(bus8.ram_data);
      wr_data3.push_back(32'(bus3.ram_data));
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    check("async_wr",      32'(bus8.ram_wr),   32'd0);
    check("async_data",    bus8.ram_data,      32'd0);
    check("async_mic",     32'(bus8.mic_clk),  32'd0);
    check("async_data_w3", 32'(bus3.ram_data), 32'd0);
    repeat (n) tick(1'b0, 1'b0);
    rst = 1'b1;
    wr_cycles.delete();
    wr_data8.delete();
    wr_data3.delete();
  endtask

  initial begin
    int drop_at;
    int drop_left;
    int p;
    bit en;
    int s;

    // Reset, then idle: mic clock runs, no writes.
    do_reset(5);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    check("idle_wr_count", 32'(wr_cycles.size()), 32'd0);

    // Constant ones (and 3-bit saturation on the second instance).
    do_reset(2);
    for (int i = 0; i < 140; i++) tick(1'b1, 1'b1);
    check("ones_wr_count", 32'(wr_cycles.size()), 32'd1);
    check("ones_wr_cycle", 32'(wr_at(0)), 32'd128);
    check("ones_word",     wd8_at(0), 32'h0808_0808);
    check("sat_word_w3",   wd3_at(0), 32'h0000_0FFF);

    // Lane order: window w carries w+1 ones.
    do_reset(2);
    for (int i = 0; i < 140; i++) begin
      s = cyc / MIC_DIV;
      tick(1'b1, 1'((s % CLOCKS) < (s / CLOCKS) + 1));
    end
    check("lane_word",    wd8_at(0), 32'h0403_0201);
    check("lane_word_w3", wd3_at(0), 32'h0000_08D1);

    // Handshake: drop count_en for the ram_wr cycle; once also on a strobe.
    do_reset(2);
    drop_at = -1;
    for (int i = 0; i < 420; i++) begin
      tick(!bus8.ram_wr && (cyc != drop_at), 1'b1);
      if (bus8.ram_wr && wr_cycles.size() == 2) drop_at = cyc + 11;
    end
    check("hs_wr_count",   32'(wr_cycles.size()), 32'd3);
    check("hs_first",      32'(wr_at(0)), 32'd128);
    check("hs_spacing",    32'(wr_at(1) - wr_at(0)), 32'd128);
    check("hs_skip_space", 32'(wr_at(2) - wr_at(1)), 32'd132);
    check("hs_word1",      wd8_at(1), 32'h0808_0808);
    check("hs_word2",      wd8_at(2), 32'h0808_0808);

    // Three-cycle drop mid-word clears partials.
    do_reset(2);
    for (int i = 0; i < 220; i++) tick(!(cyc >= 60 && cyc <= 62), 1'b1);
    check("drop3_wr_count", 32'(wr_cycles.size()), 32'd1);
    check("drop3_wr_cycle", 32'(wr_at(0)), 32'd192);
    check("drop3_word",     wd8_at(0), 32'h0808_0808);

    // Reset asserted while ram_wr is high, then mid-word after 20 strobes.
    do_reset(2);
    for (int i = 0; i < 129; i++) tick(1'b1, 1'b1);
    check("pre_rst_wr_cycle", 32'(wr_at(0)), 32'd128);
    do_reset(3);
    for (int i = 0; i < 81; i++) tick(1'b1, 1'b1);
    do_reset(3);
    for (int i = 0; i < 140; i++) tick(1'b1, 1'b1);
    check("restart_wr_cycle", 32'(wr_at(0)), 32'd128);
    check("restart_word",     wd8_at(0), 32'h0808_0808);

    // Randomized episodes at several ones densities with sporadic drops.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset(2 + int'($urandom_range(0, 3)));
      p = (ep == 0) ? 100 : (ep == 1) ? 95 : (ep == 2) ? 50 : int'($urandom_range(0, 100));
      drop_left = 0;
      for (int i = 0; i < 1200; i++) begin
        if (drop_left == 0 && $urandom_range(0, 149) == 0) drop_left = int'($urandom_range(1, 3));
        en = (drop_left == 0);
        if (drop_left > 0) drop_left--;
        tick(en, 1'(int'($urandom_range(0, 99)) < p));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_sample_packer.md
# pdm_sample_packer

Front-end PDM capture stage for the voice path. It generates the microphone bit clock and counts ones in the PDM bitstream over a fixed window to form one amplitude sample. It packs four consecutive samples into one RAM word and pulses a write strobe. It sits directly upstream of the voice control FSM: its `ram_data`/`ram_wr` feed the recording RAM and the control FSM's address counter, and that FSM gates it with `count_en`.

## Interface
- `MIC_DIV`, default 42: clk cycles per mic_clk period. Must be even and ≥ 4.
- `CLOCKS`, default 240: PDM bits per sample window. Range 1 ≤ CLOCKS ≤ 2^COUNT_W.
- `COUNT_W`, default 8: width of the window bit counter.
- `SAMPLE_W`, default 8: width of one packed sample.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `count_en`  in  1  capture enable from the control FSM.
- `micData`  in  1  PDM data from the microphone.
- `mic_clk`  out  1  generated microphone clock.
- `ram_data`  out  4*SAMPLE_W  packed word of four samples.
- `ram_wr`  out  1  one-cycle write strobe; `ram_data` is valid while it is high.

## Operation
- **Divider:** `div` counts 0..MIC_DIV-1 and wraps.
  - `mic_clk` is registered: 1 when the next `div` < MIC_DIV/2, else 0. The result is a 50% duty cycle.
  - The divider runs continuously after reset, independent of `count_en`.
- **Bit strobe:** asserted on the cycle `div == MIC_DIV-1`, which is the last clk of the mic_clk low phase. `micData` is captured on that cycle only.
- **Capture state machine:** states IDLE, RUN, HOLD. Reset state is IDLE.
  - IDLE → RUN when `count_en` = 1.
  - RUN → HOLD when `count_en` = 0.
  - HOLD → RUN when `count_en` = 1.
  - HOLD → IDLE when `count_en` = 0.
  - Net effect: a single-cycle drop of `count_en` (the control FSM's ram_wr handshake) preserves partial state. A drop of two or more cycles clears it.
- **Partial state in IDLE:** bit count, ones count and lane index are held at 0.
- **Strobe gating:** a strobe counts only when the state is RUN and `count_en` = 1 on that same cycle. Strobes in any other case are discarded, not deferred.
- **Per counted strobe:**
  - The bit count increments.
  - The ones count adds `micData`, saturating at 2^SAMPLE_W-1.
- **End of window** (strobe with bit count == CLOCKS-1):
  - The sample value is the ones count including the current bit, saturated.
  - The sample is written into lane `lane`; lane 0 occupies bits [SAMPLE_W-1:0] and lane 3 the MSBs.
  - Bit count and ones count clear, and `lane` increments.
- **End of word** (window completes at lane 3):
  - The next cycle, `ram_data` loads the four lanes and `ram_wr` = 1 for exactly one cycle.
  - `lane` wraps to 0.
- **Holding:** `ram_data` holds its value until the next word completes.

## Timing
- **Reset:** while `rst` = 0, `mic_clk` = 0, `ram_wr` = 0, `ram_data` = 0, and `div`, state and partials are 0/IDLE.
- **After reset release:** first strobe at cycle MIC_DIV-1, counting the first active edge as cycle 0.
- **Word latency:** `ram_wr` rises 1 clk after the strobe that completes lane 3.
- **Minimum spacing:** between `ram_wr` pulses, 4·CLOCKS·MIC_DIV cycles.
- **Word completion during HOLD:** cannot occur, because completion requires a counted strobe. `ram_wr` therefore never coincides with the state entered from a `count_en` drop.
- **`count_en` falling on the completing strobe:** that strobe is discarded; the word completes on the next counted strobe.
- **Reset asserted mid-word:** all partials are lost, `ram_wr` drops immediately, and no partial word is ever written.

## Test plan
Unless stated, the bench uses `MIC_DIV`=4, `CLOCKS`=8, `SAMPLE_W`=8, `COUNT_W`=4.

1. **Reset, then idle:** hold `rst` low for 5 cycles, then release with `count_en`=0.
   - Outputs are 0 during reset.
   - `mic_clk` period is 4 clk at 50% duty.
   - `ram_wr` never asserts.
2. **Constant ones:** `count_en`=1 and `micData`=1 from release.
   - Strobes occur at cycles 3, 7, ….
   - `ram_wr` is high only at cycle 128, with `ram_data`=32'h08080808.
3. **Lane order:** drive windows containing 1, 2, 3, 4 ones respectively → `ram_data`=32'h04030201.
4. **Saturation:** set `SAMPLE_W`=3 and `micData`=1 → each 8-bit window saturates to 7, giving `ram_data`=12'hFFF.
5. **Handshake:**
   - Drop `count_en` for exactly the `ram_wr` cycle: the next word is identical and spaced by 128 cycles. If the drop lands on a strobe, that bit is skipped and the spacing grows by 4.
   - Drop `count_en` for 3 cycles mid-word: partials clear, and the next `ram_wr` follows 32 counted strobes after re-enable.
6. **Reset mid-word:** assert `rst` after 20 strobes, then restart with `micData`=1.
   - The first word after restart is 32'h08080808, with no stale lanes.
